// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage. Turns EX/MEM loads and stores into
//               data-memory requests, stalls upstream until they complete,
//               then registers the result for the store/writeback stage.
//               Define MEM_STAGE_INDIRECT_EN to enable two-access LDI/STI
//               (pointer read, then final access). Without it, LDI/STI
//               behave as LDR/STR.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [2:0]  mem_op,
    input  logic [15:0] mem_ir,
    input  logic [15:0] mem_npc,
    input  logic [15:0] mem_aluresult,
    input  logic [15:0] mem_sr_data,
    input  logic [2:0]  mem_drid,
    input  logic [3:0]  mem_cs,
    output logic        mem_stall,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        sr_valid,
    output logic [15:0] sr_address_out,
    output logic [15:0] sr_data_out,
    output logic [15:0] sr_npc_out,
    output logic [15:0] sr_aluresult_out,
    output logic [15:0] sr_ir_out,
    output logic [2:0]  sr_drid_out,
    output logic [3:0]  sr_cs_out
);

    localparam logic [2:0] c_OP_NONE = 3'b000;
    localparam logic [2:0] c_OP_LDB  = 3'b010;
    localparam logic [2:0] c_OP_STR  = 3'b011;
    localparam logic [2:0] c_OP_STB  = 3'b100;
    localparam logic [2:0] c_OP_LDI  = 3'b101;
    localparam logic [2:0] c_OP_STI  = 3'b110;
    localparam logic [2:0] c_OP_RSVD = 3'b111;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ACC1 = 2'd1;
`ifdef MEM_STAGE_INDIRECT_EN
    localparam logic [1:0] c_ST_ACC2 = 2'd2;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        w_is_mem;
    logic        w_is_store;
    logic        w_is_byte;
    logic        w_ptr_read;
    logic        w_stall;
    logic        w_done;
    logic [15:0] w_acc_addr;
    logic [7:0]  w_byte;
    logic [15:0] w_load_data;

`ifdef MEM_STAGE_INDIRECT_EN
    logic [15:0] r_ptr;
`endif

    // Opcode classification; w_ptr_read marks ops whose first access fetches a pointer
    always_comb begin
        w_is_mem   = mem_valid && (mem_op != c_OP_NONE) && (mem_op != c_OP_RSVD);
        w_is_store = (mem_op == c_OP_STR) || (mem_op == c_OP_STB) || (mem_op == c_OP_STI);
        w_is_byte  = (mem_op == c_OP_LDB) || (mem_op == c_OP_STB);
`ifdef MEM_STAGE_INDIRECT_EN
        w_ptr_read = (mem_op == c_OP_LDI) || (mem_op == c_OP_STI);
`else
        w_ptr_read = 1'b0;
`endif
    end

    // Address of the current access (unaligned) and the data a load returns
    always_comb begin
`ifdef MEM_STAGE_INDIRECT_EN
        w_acc_addr = (r_state == c_ST_ACC2) ? r_ptr : mem_aluresult;
`else
        w_acc_addr = mem_aluresult;
`endif
        w_byte = w_acc_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
        if (mem_op == c_OP_LDB) begin
            w_load_data = {{8{w_byte[7]}}, w_byte};
        end else if (w_is_store) begin
            w_load_data = mem_sr_data;
        end else begin
            w_load_data = dmem_rdata;
        end
    end

    // Next-state logic and memory request; request only asserted in access states
    always_comb begin
        w_state_nxt      = r_state;
        w_stall          = 1'b0;
        w_done           = 1'b0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_addr        = {w_acc_addr[15:1], 1'b0};
        dmem_byte_enable = 2'b11;
        dmem_wdata       = (mem_op == c_OP_STB) ? {mem_sr_data[7:0], mem_sr_data[7:0]}
                                                : mem_sr_data;
        case (r_state)
            c_ST_IDLE: begin
                if (w_is_mem) begin
                    w_stall     = 1'b1;
                    w_state_nxt = c_ST_ACC1;
                end
            end
            c_ST_ACC1: begin
                if (w_is_byte) begin
                    dmem_byte_enable = w_acc_addr[0] ? 2'b10 : 2'b01;
                end
                // A pointer fetch is always a read, even for STI
                dmem_read  = w_ptr_read | ~w_is_store;
                dmem_write = ~w_ptr_read & w_is_store;
                if (!dmem_resp) begin
                    w_stall = 1'b1;
                end
`ifdef MEM_STAGE_INDIRECT_EN
                else if (w_ptr_read) begin
                    w_stall     = 1'b1;
                    w_state_nxt = c_ST_ACC2;
                end
`endif
                else begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
`ifdef MEM_STAGE_INDIRECT_EN
            c_ST_ACC2: begin
                dmem_read  = ~w_is_store;
                dmem_write = w_is_store;
                if (dmem_resp) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held, even if upstream presents a memory op
    assign mem_stall = w_stall & reset_n;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef MEM_STAGE_INDIRECT_EN
    // Pointer returned by the first indirect access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 16'h0000;
        end else if ((r_state == c_ST_ACC1) && w_ptr_read && dmem_resp) begin
            r_ptr <= dmem_rdata;
        end
    end
`endif

    // Store/writeback stage registers: pass-through in IDLE, load on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_valid         <= 1'b0;
            sr_address_out   <= 16'h0000;
            sr_data_out      <= 16'h0000;
            sr_npc_out       <= 16'h0000;
            sr_aluresult_out <= 16'h0000;
            sr_ir_out        <= 16'h0000;
            sr_drid_out      <= 3'b000;
            sr_cs_out        <= 4'b0000;
        end else if (((r_state == c_ST_IDLE) && !w_is_mem) || w_done) begin
            sr_valid         <= w_done ? 1'b1 : mem_valid;
            sr_address_out   <= w_done ? w_acc_addr : mem_aluresult;
            sr_data_out      <= w_done ? w_load_data : mem_sr_data;
            sr_npc_out       <= mem_npc;
            sr_aluresult_out <= mem_aluresult;
            sr_ir_out        <= mem_ir;
            sr_drid_out      <= mem_drid;
            sr_cs_out        <= mem_cs;
        end else begin
            sr_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (word 16, nzp/drid 3, cs 4).
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 mem_valid  in  1  upstream (EX/MEM) holds a valid instruction.
REQ-005 mem_op  in  3  000 none, 001 LDR, 010 LDB, 011 STR, 100 STB, 101 LDI, 110 STI; 111 is treated as none.
REQ-006 mem_ir, mem_npc, mem_aluresult, mem_sr_data  in  16 each  instruction, next PC, ALU result/effective address, store data.
REQ-007 mem_drid  in  3, mem_cs  in  4  destination register id, writeback control bits.
REQ-008 mem_stall  out  1  upstream SHALL hold all mem_* inputs stable while this is high.
REQ-009 dmem_addr  out  16, dmem_wdata  out  16, dmem_read  out  1, dmem_write  out  1, dmem_byte_enable  out  2  data-memory request.
REQ-010 dmem_rdata  in  16, dmem_resp  in  1  data-memory read data and single-cycle completion pulse.
REQ-011 sr_valid  out  1  registered; marks a valid instruction for the store/writeback stage.
REQ-012 sr_address_out, sr_data_out, sr_npc_out, sr_aluresult_out, sr_ir_out  out  16 each; sr_drid_out  out  3; sr_cs_out  out  4; all registered.

Function
REQ-013 FSM states: IDLE, ACC1, ACC2; dmem_read/dmem_write SHALL be driven only in ACC1/ACC2.
REQ-014 IDLE, with mem_valid=0 or op none: next cycle sr_valid equals mem_valid, sr_* capture inputs, mem_stall=0, state stays IDLE (1-cycle latency).
REQ-015 IDLE, with mem_valid=1 and a memory op: mem_stall=1, next state ACC1, sr_valid=0 next cycle.
REQ-016 ACC1/ACC2: the request SHALL be held constant until dmem_resp=1; mem_stall=1 except in the completing cycle.
REQ-017 ACC1 + dmem_resp, op LDI/STI: latch dmem_rdata as pointer, go to ACC2; otherwise complete.
REQ-018 Completion: in the dmem_resp cycle mem_stall=0; next edge loads sr_* from the current inputs with sr_valid=1 and returns to IDLE.
REQ-019 Addressing: word ops (LDR/STR/LDI/STI, and the pointer read) drive dmem_addr = address with bit0 cleared and byte_enable=11.
REQ-020 Byte ops: dmem_addr = address with bit0 cleared; byte_enable=01 if address[0]=0, else 10.
REQ-021 STB: dmem_wdata = {sr_data[7:0], sr_data[7:0]}; STR/STI: dmem_wdata = mem_sr_data.
REQ-022 LDB: sr_data_out = selected byte sign-extended to 16 bits; LDR/LDI: sr_data_out = dmem_rdata; stores: sr_data_out = mem_sr_data.
REQ-023 sr_address_out SHALL equal the address of the final access (the pointer for LDI/STI); non-memory ops pass mem_aluresult.
REQ-024 dmem_resp SHALL be ignored in IDLE.
REQ-025 LDI/STI first access SHALL always be a read, regardless of load or store.

Reset
REQ-026 With reset_n=0, the block SHALL immediately enter IDLE with dmem_read=0, dmem_write=0, mem_stall=0, sr_valid=0 and all sr_* outputs 0, including mid-access.
REQ-027 A dmem_resp that arrives after a mid-access reset SHALL be discarded.

Configuration
REQ-028 When MEM_STAGE_INDIRECT_EN is defined, LDI/STI SHALL use the two-access ACC1->ACC2 sequence.
REQ-029 When MEM_STAGE_INDIRECT_EN is undefined, ACC2 and the pointer register SHALL be absent and LDI/STI SHALL behave exactly as LDR/STR.

Verification
REQ-030 ADD (op 000), mem_aluresult=16'h1234 -> next cycle sr_valid=1, sr_aluresult_out=16'h1234, no dmem request, mem_stall never 1.
REQ-031 LDB at address 16'h3001, resp after 3 cycles with rdata=16'h80FF -> dmem_addr=16'h3000, byte_enable=10, sr_data_out=16'hFF80, mem_stall high for 3 cycles.
REQ-032 STB at address 16'h4000, data=16'hABCD -> dmem_write=1, wdata=16'hCDCD, byte_enable=01; sr_valid=1 the cycle after resp.
REQ-033 LDI at address 16'h5000, first rdata=16'h6002, second rdata=16'hBEEF -> reads at 16'h5000 then 16'h6002, sr_address_out=16'h6002, sr_data_out=16'hBEEF; without the macro, only one read with sr_data_out=16'h6002.
REQ-034 reset_n low while in ACC1 before resp, late resp injected -> dmem_read drops at once, sr_valid stays 0, FSM in IDLE.
